l2_bank_xbar: RTL and testbench

Parametrised multi-port, multi-bank L2 memory with a built-in crossbar. It is the successor to the single-port JTAG-to-L2 path. NB_MASTERS lint (TCDM-style req/gnt/r_valid) masters, such as the JTAG lint bridge and future DMA/core ports, share NB_BANKS single-cycle SRAM banks. Bank selection is word-interleaved or contiguous, each bank has its own round-robin arbiter, and out-of-range accesses are flagged as errors.

---
 rtl/l2_xbar_pkg.sv | 55 +++++
 rtl/l2_bank_sram.sv | 29 ++
 rtl/l2_bank_xbar.sv | 151 +++++++++++++++
 tb/tb_l2_bank_xbar.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_xbar_pkg.sv
// Shared types, constants and address decode for the multi-bank L2 crossbar.
// Decode helpers are written so that constant parameter arguments fold away.
package l2_xbar_pkg;

    localparam logic [31:0] ERR_RDATA = 32'hBADA_CCE5;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        opc;
    } resp_t;

    typedef struct packed {
        logic        in_range;
        logic [31:0] bank;
        logic [31:0] row;
    } dec_t;

    function automatic int log2_pow2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if (value == (1 << i)) result = i;
        end
        return result;
    endfunction

    // Word-interleaved: bank in the low word bits. Contiguous: row in the low bits.
    function automatic dec_t decode_bank_row(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int          interleave,
        input int          nb_banks,
        input int          bank_words
    );
        dec_t        d;
        logic [31:0] word;
        logic [31:0] bank_mask;
        logic [31:0] row_mask;
        word      = (addr - base) >> 2;
        bank_mask = 32'(nb_banks - 1);
        row_mask  = 32'(bank_words - 1);
        if (interleave != 0) begin
            d.bank = word & bank_mask;
            d.row  = (word >> log2_pow2(nb_banks)) & row_mask;
        end else begin
            d.row  = word & row_mask;
            d.bank = (word >> log2_pow2(bank_words)) & bank_mask;
        end
        d.in_range = (addr >= base) &&
                     ({32'd0, word} < (64'(nb_banks) * 64'(bank_words)));
        return d;
    endfunction

endpackage

// File: rtl/l2_bank_sram.sv
// Single-port SRAM bank with byte-enable writes and a registered read port.
// Read data is only updated on read requests; contents are never reset.
module l2_bank_sram #(
    parameter int WORDS = 8192,
    parameter int AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic          clk_i,
    input  logic          req_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk_i) begin
        if (req_i && we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        if (req_i && !we_i) begin
            rdata_o <= mem[addr_i];
        end
    end

endmodule

// File: rtl/l2_bank_xbar.sv
// Multi-master, multi-bank L2 with per-bank round-robin arbitration.
// Out-of-range requests bypass arbitration and answer with an error response.
module l2_bank_xbar
    import l2_xbar_pkg::*;
#(
    parameter int          NB_MASTERS = 2,
    parameter int          NB_BANKS   = 4,
    parameter int          BANK_WORDS = 8192,
    parameter int          INTERLEAVE = 1,
    parameter logic [31:0] BASE_ADDR  = 32'h1C00_0000
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NB_MASTERS-1:0]       m_req_i,
    input  logic [NB_MASTERS-1:0][31:0] m_add_i,
    input  logic [NB_MASTERS-1:0]       m_wen_i,
    input  logic [NB_MASTERS-1:0][31:0] m_wdata_i,
    input  logic [NB_MASTERS-1:0][3:0]  m_be_i,
    output logic [NB_MASTERS-1:0]       m_gnt_o,
    output logic [NB_MASTERS-1:0]       m_r_valid_o,
    output logic [NB_MASTERS-1:0][31:0] m_r_rdata_o,
    output logic [NB_MASTERS-1:0]       m_r_opc_o
);

    localparam int MW = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;
    localparam int BW = (NB_BANKS > 1) ? $clog2(NB_BANKS) : 1;
    localparam int RW = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;

    dec_t                  w_dec        [NB_MASTERS];
    logic [NB_MASTERS-1:0] w_bank_gnt   [NB_BANKS];
    logic [31:0]           w_bank_rdata [NB_BANKS];

    genvar gi;

    for (gi = 0; gi < NB_BANKS; gi++) begin : g_bank
        logic [NB_MASTERS-1:0] w_req;
        logic [NB_MASTERS-1:0] w_gnt_vec;
        logic                  w_found;
        logic [MW-1:0]         w_sel;
        logic [MW-1:0]         r_rr;

        always_comb begin
            w_req = '0;
            for (int m = 0; m < NB_MASTERS; m++) begin
                w_req[m] = m_req_i[m] && w_dec[m].in_range &&
                           (w_dec[m].bank == 32'(gi)) && !rst_i;
            end
        end

        // Scan from the priority pointer, wrapping once around the masters.
        always_comb begin
            int k;
            k         = 0;
            w_found   = 1'b0;
            w_sel     = '0;
            w_gnt_vec = '0;
            for (int i = 0; i < NB_MASTERS; i++) begin
                k = int'(r_rr) + i;
                if (k >= NB_MASTERS) k = k - NB_MASTERS;
                if (!w_found && w_req[k]) begin
                    w_found = 1'b1;
                    w_sel   = MW'(k);
                end
            end
            if (w_found) w_gnt_vec[w_sel] = 1'b1;
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_rr <= '0;
            end else if (w_found) begin
                r_rr <= (w_sel == MW'(NB_MASTERS - 1)) ? '0 : w_sel + 1'b1;
            end
        end

        assign w_bank_gnt[gi] = w_gnt_vec;

        l2_bank_sram #(
            .WORDS (BANK_WORDS),
            .AW    (RW)
        ) u_sram (
            .clk_i   (clk_i),
            .req_i   (w_found),
            .we_i    (!m_wen_i[w_sel]),
            .be_i    (m_be_i[w_sel]),
            .addr_i  (RW'(w_dec[w_sel].row)),
            .wdata_i (m_wdata_i[w_sel]),
            .rdata_o (w_bank_rdata[gi])
        );
    end

    for (gi = 0; gi < NB_MASTERS; gi++) begin : g_master
        logic          w_oor_gnt;
        logic          w_any_bank;
        logic          w_gnt;
        logic          w_unused_dec;
        resp_t         w_resp;
        logic          r_valid;
        logic          r_err;
        logic          r_read;
        logic [BW-1:0] r_bank;

        assign w_dec[gi] = decode_bank_row(m_add_i[gi], BASE_ADDR, INTERLEAVE,
                                           NB_BANKS, BANK_WORDS);
        assign w_unused_dec = ^{w_dec[gi].bank, w_dec[gi].row};
        assign w_oor_gnt = m_req_i[gi] && !w_dec[gi].in_range && !rst_i;

        always_comb begin
            w_any_bank = 1'b0;
            for (int b = 0; b < NB_BANKS; b++) begin
                w_any_bank = w_any_bank | w_bank_gnt[b][gi];
            end
        end

        assign w_gnt = w_oor_gnt | w_any_bank;

        // Remember where this grant went so the next cycle can route its response.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_valid <= 1'b0;
                r_err   <= 1'b0;
                r_read  <= 1'b0;
                r_bank  <= '0;
            end else begin
                r_valid <= w_gnt;
                r_err   <= w_oor_gnt;
                r_read  <= w_gnt && m_wen_i[gi];
                r_bank  <= BW'(w_dec[gi].bank);
            end
        end

        always_comb begin
            w_resp.valid = r_valid && !rst_i;
            w_resp.opc   = r_valid && r_err && !rst_i;
            w_resp.rdata = '0;
            if (w_resp.valid) begin
                if (r_err) begin
                    w_resp.rdata = ERR_RDATA;
                end else if (r_read) begin
                    w_resp.rdata = w_bank_rdata[r_bank];
                end
            end
        end

        assign m_gnt_o[gi]     = w_gnt;
        assign m_r_valid_o[gi] = w_resp.valid;
        assign m_r_rdata_o[gi] = w_resp.rdata;
        assign m_r_opc_o[gi]   = w_resp.opc;
    end

endmodule

// File: tb/tb_l2_bank_xbar.sv
// Scoreboard bench: grants push expected responses, a negedge monitor pops and checks them.
// A second instance covers the contiguous bank map.
module tb_l2_bank_xbar;

    localparam logic [31:0] BASE = 32'h1C00_0000;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        opc;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [1:0]       req, wen, gnt, rv, opc;
    logic [1:0][31:0] add, wdata, rdata;
    logic [1:0][3:0]  be;

    logic [1:0]       d2_req, d2_wen, d2_gnt, d2_rv, d2_opc;
    logic [1:0][31:0] d2_add, d2_wdata, d2_rdata;
    logic [1:0][3:0]  d2_be;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    exp_t        sbq [2][$];
    logic [31:0] mdl [int];

    l2_bank_xbar #(.NB_MASTERS(2), .NB_BANKS(4), .BANK_WORDS(8192), .INTERLEAVE(1),
                   .BASE_ADDR(32'h1C00_0000)) u_dut (
        .clk_i(clk), .rst_i(rst), .m_req_i(req), .m_add_i(add), .m_wen_i(wen),
        .m_wdata_i(wdata), .m_be_i(be), .m_gnt_o(gnt), .m_r_valid_o(rv),
        .m_r_rdata_o(rdata), .m_r_opc_o(opc)
    );

    l2_bank_xbar #(.NB_MASTERS(2), .NB_BANKS(4), .BANK_WORDS(8192), .INTERLEAVE(0),
                   .BASE_ADDR(32'h1C00_0000)) u_dut_contig (
        .clk_i(clk), .rst_i(rst), .m_req_i(d2_req), .m_add_i(d2_add), .m_wen_i(d2_wen),
        .m_wdata_i(d2_wdata), .m_be_i(d2_be), .m_gnt_o(d2_gnt), .m_r_valid_o(d2_rv),
        .m_r_rdata_o(d2_rdata), .m_r_opc_o(d2_opc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    always @(negedge clk) begin
        exp_t e;
        for (int m = 0; m < 2; m++) begin
            if (rv[m] === 1'b1) begin
                n_checks++;
                if (sbq[m].size() == 0) begin
                    $display("FAIL unexpected_rvalid m%0d cyc %0d: got r_valid=1 rdata=%h, required no response",
                             m, cyc, rdata[m]);
                end else begin
                    e = sbq[m].pop_front();
                    if (e.due != cyc || rdata[m] !== e.rdata || opc[m] !== e.opc)
                        $display("FAIL response m%0d: got cyc=%0d rdata=%h opc=%b, required cyc=%0d rdata=%h opc=%b",
                                 m, cyc, rdata[m], opc[m], e.due, e.rdata, e.opc);
                    else
                        n_pass++;
                end
            end else if (sbq[m].size() != 0 && sbq[m][0].due <= cyc) begin
                n_checks++;
                $display("FAIL missing_rvalid m%0d: got r_valid=%b at cyc %0d, required 1",
                         m, rv[m], cyc);
                e = sbq[m].pop_front();
            end
        end
    end

    function automatic bit tb_oor(input logic [31:0] a);
        return (a < BASE) || (((a - BASE) >> 2) >= 32'd32768);
    endfunction

    task automatic drive(input int m, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] b);
        req[m] = 1'b1; add[m] = a; wen[m] = w; wdata[m] = d; be[m] = b;
    endtask

    task automatic idle(input int m);
        req[m] = 1'b0;
    endtask

    // Samples grants for the current cycle and queues the response each one must produce.
    task automatic grant_cycle(output logic [1:0] g);
        exp_t        e;
        int          w;
        logic [31:0] cur;
        @(negedge clk); #1;
        g = gnt;
        for (int m = 0; m < 2; m++) begin
            if (g[m]) begin
                e.due = cyc + 1;
                if (tb_oor(add[m])) begin
                    e.rdata = 32'hBADA_CCE5;
                    e.opc   = 1'b1;
                end else begin
                    w     = int'((add[m] - BASE) >> 2);
                    e.opc = 1'b0;
                    if (wen[m]) begin
                        e.rdata = mdl[w];
                    end else begin
                        cur = mdl.exists(w) ? mdl[w] : 32'h0;
                        for (int b = 0; b < 4; b++)
                            if (be[m][b]) cur[8*b +: 8] = wdata[m][8*b +: 8];
                        mdl[w]  = cur;
                        e.rdata = 32'h0;
                    end
                end
                sbq[m].push_back(e);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [1:0] g;
        rst = 1'b1;
        drive(0, BASE, 1'b1, 32'h0, 4'hF);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        g = gnt;
        n_checks++; if (g !== 2'b00) $display("FAIL reset_gnt: got %b, required 00", g); else n_pass++;
        n_checks++; if (rv !== 2'b00) $display("FAIL reset_rvalid: got %b, required 00", rv); else n_pass++;
        n_checks++; if (opc !== 2'b00) $display("FAIL reset_opc: got %b, required 00", opc); else n_pass++;
        n_checks++;
        if (rdata[0] !== 32'h0 || rdata[1] !== 32'h0)
            $display("FAIL reset_rdata: got %h %h, required 0 0", rdata[0], rdata[1]);
        else n_pass++;
        idle(0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [1:0] g;
        drive(0, 32'h1C00_0004, 1'b0, 32'hDEAD_BEEF, 4'hF);
        grant_cycle(g);
        n_checks++; if (g !== 2'b01) $display("FAIL single_wr_gnt: got %b, required 01", g); else n_pass++;
        drive(0, 32'h1C00_0004, 1'b1, 32'h0, 4'hF);
        grant_cycle(g);
        n_checks++; if (g !== 2'b01) $display("FAIL single_rd_gnt: got %b, required 01", g); else n_pass++;
        // 0x14 is bank 1 as well; rr of bank 1 now points at M1.
        drive(1, 32'h1C00_0014, 1'b0, 32'h0BAD_0014, 4'hF);
        grant_cycle(g);
        n_checks++; if (g !== 2'b10) $display("FAIL bank1_share_gnt: got %b, required 10", g); else n_pass++;
        idle(1);
        grant_cycle(g);
        n_checks++; if (g !== 2'b01) $display("FAIL bank1_retry_gnt: got %b, required 01", g); else n_pass++;
        drive(0, 32'h1C00_0014, 1'b1, 32'h0, 4'hF);
        grant_cycle(g);
        idle(0);
        grant_cycle(g);
    endtask

    task automatic test_byte_en();
        logic [1:0] g;
        drive(0, 32'h1C00_0020, 1'b0, 32'h1122_3344, 4'b1111);
        grant_cycle(g);
        drive(0, 32'h1C00_0020, 1'b0, 32'hAABB_CCDD, 4'b0101);
        grant_cycle(g);
        n_checks++; if (g !== 2'b01) $display("FAIL be_wr_gnt: got %b, required 01", g); else n_pass++;
        drive(0, 32'h1C00_0020, 1'b1, 32'h0, 4'hF);
        grant_cycle(g);
        idle(0);
        grant_cycle(g);
    endtask

    task automatic test_no_conflict();
        logic [1:0] g;
        drive(0, 32'h1C00_0000, 1'b0, 32'h00C0_FFEE, 4'hF);
        drive(1, 32'h1C00_0004, 1'b0, 32'h1234_5678, 4'hF);
        grant_cycle(g);
        n_checks++; if (g !== 2'b11) $display("FAIL noconf_wr_gnt: got %b, required 11", g); else n_pass++;
        drive(0, 32'h1C00_0000, 1'b1, 32'h0, 4'hF);
        drive(1, 32'h1C00_0004, 1'b1, 32'h0, 4'hF);
        grant_cycle(g);
        n_checks++; if (g !== 2'b11) $display("FAIL noconf_rd_gnt: got %b, required 11", g); else n_pass++;
        idle(0); idle(1);
        grant_cycle(g);
    endtask

    task automatic test_back_to_back();
        logic [1:0] g;
        logic [31:0] seq_addr [3];
        seq_addr[0] = 32'h1C00_0020; seq_addr[1] = 32'h1C00_0000; seq_addr[2] = 32'h1C00_0014;
        for (int i = 0; i < 3; i++) begin
            drive(0, seq_addr[i], 1'b1, 32'h0, 4'hF);
            grant_cycle(g);
            n_checks++; if (g !== 2'b01) $display("FAIL b2b_gnt%0d: got %b, required 01", i, g); else n_pass++;
        end
        drive(0, 32'h1C00_0030, 1'b0, 32'h600D_F00D, 4'hF);
        grant_cycle(g);
        drive(0, 32'h1C00_0030, 1'b1, 32'h0, 4'hF);
        grant_cycle(g);
        idle(0);
        grant_cycle(g);
    endtask

    task automatic test_errors();
        logic [1:0] g;
        drive(0, 32'h1C02_0000, 1'b1, 32'h0, 4'hF);
        drive(1, 32'h1C02_0000, 1'b0, 32'hFFFF_FFFF, 4'hF);
        grant_cycle(g);
        n_checks++; if (g !== 2'b11) $display("FAIL oor_both_gnt: got %b, required 11", g); else n_pass++;
        drive(0, 32'h1C00_0000, 1'b1, 32'h0, 4'hF);
        drive(1, 32'h1BFF_FFFC, 1'b1, 32'h0, 4'hF);
        grant_cycle(g);
        n_checks++; if (g !== 2'b11) $display("FAIL oor_mixed_gnt: got %b, required 11", g); else n_pass++;
        idle(0); idle(1);
        grant_cycle(g);
    endtask

    task automatic test_reset_pending();
        logic [1:0] g;
        drive(0, 32'h1C00_0010, 1'b0, 32'h5A5A_0010, 4'hF);
        grant_cycle(g);
        // This grant is deliberately not queued: reset must swallow its response.
        drive(0, 32'h1C00_0000, 1'b1, 32'h0, 4'hF);
        @(negedge clk); #1;
        n_checks++; if (gnt !== 2'b01) $display("FAIL pend_gnt: got %b, required 01", gnt); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        n_checks++; if (rv !== 2'b00) $display("FAIL pend_rvalid: got %b, required 00", rv); else n_pass++;
        n_checks++; if (gnt !== 2'b00) $display("FAIL rst_gnt_forced: got %b, required 00", gnt); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(0);
        grant_cycle(g);
        drive(0, 32'h1C00_0010, 1'b1, 32'h0, 4'hF);
        drive(1, 32'h1C00_0010, 1'b1, 32'h0, 4'hF);
        for (int i = 0; i < 4; i++) begin
            grant_cycle(g);
            n_checks++;
            if (g !== ((i % 2 == 0) ? 2'b01 : 2'b10))
                $display("FAIL conflict_gnt%0d: got %b, required %b", i, g,
                         (i % 2 == 0) ? 2'b01 : 2'b10);
            else n_pass++;
        end
        idle(0); idle(1);
        grant_cycle(g);
    endtask

    task automatic test_interleave0();
        d2_req = 2'b11; d2_wen = 2'b00; d2_be[0] = 4'hF; d2_be[1] = 4'hF;
        d2_add[0] = 32'h1C00_0000; d2_wdata[0] = 32'hA0A0_A0A0;
        d2_add[1] = 32'h1C00_8000; d2_wdata[1] = 32'hB1B1_B1B1;
        @(negedge clk); #1;
        n_checks++; if (d2_gnt !== 2'b11) $display("FAIL contig_wr_gnt: got %b, required 11", d2_gnt); else n_pass++;
        @(posedge clk); #1;
        d2_wen = 2'b11;
        @(negedge clk); #1;
        n_checks++; if (d2_gnt !== 2'b11) $display("FAIL contig_rd_gnt: got %b, required 11", d2_gnt); else n_pass++;
        n_checks++;
        if (d2_rv !== 2'b11 || d2_opc !== 2'b00 || d2_rdata[0] !== 32'h0)
            $display("FAIL contig_wr_resp: got rv=%b opc=%b rdata=%h, required 11 00 0", d2_rv, d2_opc, d2_rdata[0]);
        else n_pass++;
        @(posedge clk); #1;
        d2_req = 2'b00;
        @(negedge clk); #1;
        n_checks++;
        if (d2_rv !== 2'b11 || d2_rdata[0] !== 32'hA0A0_A0A0 || d2_rdata[1] !== 32'hB1B1_B1B1)
            $display("FAIL contig_rd_resp: got rv=%b %h %h, required 11 a0a0a0a0 b1b1b1b1",
                     d2_rv, d2_rdata[0], d2_rdata[1]);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_drain();
        repeat (3) @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if (sbq[m].size() != 0)
                $display("FAIL drain_m%0d: got %0d pending, required 0", m, sbq[m].size());
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1;
        req = '0; wen = '0; add = '0; wdata = '0; be = '0;
        d2_req = '0; d2_wen = '0; d2_add = '0; d2_wdata = '0; d2_be = '0;
        test_reset();
        test_single();
        test_byte_en();
        test_no_conflict();
        test_back_to_back();
        test_errors();
        test_reset_pending();
        test_interleave0();
        test_drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
